// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch-side bus: instruction memory read port and decoder link
interface fetch_sequencer_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int IDX_W   = 4
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               pc_jmp_en;
  logic [IDX_W-1:0]   lut_ptr;

  modport master (
    output imem_addr, instr, instr_valid, pc,
    input  imem_rdata, pc_jmp_en, lut_ptr
  );

  modport slave (
    input  imem_addr, instr, instr_valid, pc,
    output imem_rdata, pc_jmp_en, lut_ptr
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch / PC sequencer with 16-entry jump-target LUT
module fetch_sequencer #(
  parameter int                 PC_W      = 10,
  parameter int                 INSTR_W   = 9,
  parameter int                 LUT_DEPTH = 16,
  parameter logic [INSTR_W-1:0] HALT_WORD = 9'h1FF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         lut_wr_en,
  input  logic [$clog2(LUT_DEPTH)-1:0] lut_wr_idx,
  input  logic [PC_W-1:0]              lut_wr_data,
  output logic                         busy,
  output logic                         done,
  fetch_sequencer_if.master            bus
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [PC_W-1:0]   lut [LUT_DEPTH];
  logic [PC_W-1:0]   jmp_target;

  // Combinational read sees the pre-write value when a write lands in the same cycle.
  assign jmp_target = lut[bus.lut_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (lut_wr_en) begin
      lut[lut_wr_idx] <= lut_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          pc_d    = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        addr_d  = addr_q + PC_W'(1);
        valid_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (valid_q) begin
          if (bus.imem_rdata == HALT_WORD) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else if (bus.pc_jmp_en) begin
            // Drop the in-flight sequential word; FILL re-primes the read pipe.
            addr_d  = jmp_target;
            pc_d    = jmp_target;
            valid_d = 1'b0;
            state_d = FILL;
          end else begin
            addr_d = addr_q + PC_W'(1);
            pc_d   = pc_q + PC_W'(1);
          end
        end
      end
      DONE: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state_q == FILL) || (state_q == RUN);
  assign done            = (state_q == DONE);
  assign bus.imem_addr   = addr_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = valid_q ? bus.imem_rdata : '0;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and program-counter sequencer. It produces the 9-bit instruction word and its valid qualifier for the control decoder.
- It consumes the decoder's jump request (pc_jmp_en) and jump-table index (lut_ptr).
- It owns the PC, the 16-entry jump-target LUT, the instruction-memory read address, and the start/done program handshake for the top level.

Parameters:
- PC_W, 10, width of PC, imem address and LUT entries
- INSTR_W, 9, instruction width
- LUT_DEPTH, 16, jump-target entries; index width is 4
- HALT_WORD, 9'h1FF, instruction word that ends the program

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- start  in  1  pulse; begins execution at address 0 when idle
- lut_wr_en  in  1  write one jump-LUT entry
- lut_wr_idx  in  4  LUT entry index
- lut_wr_data  in  PC_W  jump target address
- imem_addr  out  PC_W  instruction-memory read address (registered)
- imem_rdata  in  INSTR_W  word at the imem_addr of the previous cycle (1-cycle synchronous read)
- instr  out  INSTR_W  instruction to the decoder; 0 when instr_valid=0
- instr_valid  out  1  instr is a real instruction this cycle
- pc_jmp_en  in  1  from decoder, same cycle as instr; taken jump
- lut_ptr  in  4  from decoder; jump-table index
- pc  out  PC_W  address of the word currently on instr
- busy  out  1  program running
- done  out  1  one-cycle pulse at program end

Behaviour:
- Async reset (rst_n=0): state IDLE; pc=0; imem_addr=0; instr_valid=0; busy=0; done=0; all LUT entries=0. Reset mid-run abandons the program immediately; no done pulse.
- States:
  - IDLE: busy=0. start=1 → imem_addr<=0, pc<=0, go FILL.
  - FILL: busy=1; memory is reading the address in imem_addr; imem_addr<=imem_addr+1; go RUN with instr_valid<=1.
  - RUN: busy=1; instr=imem_rdata, pc=address of that word. Per cycle with instr_valid=1:
    - instr==HALT_WORD → instr_valid<=0, go DONE. pc_jmp_en is ignored on the halt word.
    - else pc_jmp_en=1 → imem_addr<=lut[lut_ptr], pc<=lut[lut_ptr], go FILL. The in-flight sequential word is discarded: exactly one bubble cycle with instr_valid=0. Taken-jump cost: 2 cycles from jump instr to target instr.
    - else → imem_addr<=imem_addr+1, pc<=pc+1, instr_valid stays 1.
  - DONE: done=1 for exactly one cycle, busy=0, instr_valid=0; go IDLE.
- Latency: start at cycle t → first instr_valid at t+2. Sequential throughput is 1 instruction/cycle.
- Address arithmetic is modulo 2^PC_W: PC 1023 → 0 with no error.
- start while not IDLE is ignored. start in the same cycle as DONE is ignored; it must be reissued in IDLE.
- LUT:
  - Writes are accepted in any state.
  - A write and a jump read to the same index in the same cycle → the jump uses the old value.
  - The LUT is not cleared by start.
- instr is forced to 0 when instr_valid=0. The decoder side must gate all write enables and flag updates with instr_valid.
- pc_jmp_en/lut_ptr are ignored whenever instr_valid=0.

Test Plan:
- Reset then start, memory words 0..3 = 9'h040,9'h048,9'h050,9'h1FF, no jumps → instr_valid at t+2 with pc 0,1,2 on consecutive cycles; halt at pc 3 → done pulse 1 cycle later, busy=0, exactly 3 valid non-halt instrs.
- LUT[5]=10'd100 written; jump instr at pc 7 with pc_jmp_en=1, lut_ptr=5 → next cycle instr_valid=0, following cycle pc=100 and instr=mem[100]; word at address 8 is never issued.
- LUT write to idx 5 (value 200) in the same cycle as a jump using idx 5 (old value 100) → target 100; a later jump via idx 5 → 200.
- Program straddling the top: LUT[0]=1022, jump, then no halt until address 1 → pc sequence 1022,1023,0,1; no stall at wrap.
- start pulsed during RUN and in the DONE cycle → ignored, no restart. rst_n low mid-RUN → outputs at reset values asynchronously, no done pulse, LUT zeroed.
- Halt word with pc_jmp_en=1 in the same cycle → no jump, DONE entered, imem_addr unchanged.
